// File: rtl/delay_and_sum_pkg.sv
// Shared width helpers and round/saturate arithmetic for the beamformer datapath blocks.
// Arithmetic runs on a wide signed type so every caller gets exact, overflow-free results.
package delay_and_sum_pkg;

    localparam int WIDE_W = 128;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [1:0] {
        SAT_NONE = 2'b00,
        SAT_HI   = 2'b01,
        SAT_LO   = 2'b10
    } sat_kind_e;

    function automatic int clog2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic int prod_width(input int din0_w, input int din1_w);
        return din0_w + din1_w;
    endfunction

    function automatic int sum_width(input int din0_w, input int din1_w, input int num_ch);
        return din0_w + din1_w + clog2(num_ch);
    endfunction

    function automatic int addr_width(input int num_ch);
        return (clog2(num_ch) > 1) ? clog2(num_ch) : 1;
    endfunction

    // Round half up: add half an LSB of the result, then arithmetic shift.
    function automatic wide_t round_shift(input wide_t value, input int shift);
        if (shift <= 0) return value;
        return (value + (wide_t'(1) <<< (shift - 1))) >>> shift;
    endfunction

    function automatic sat_kind_e sat_kind(input wide_t value, input int dout_w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (dout_w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (dout_w - 1));
        if (value > hi) return SAT_HI;
        if (value < lo) return SAT_LO;
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/delay_and_sum_round_sat.sv
// Combinational round, arithmetic shift and clamp of a signed channel sum to DOUT_WIDTH.
module delay_and_sum_round_sat
    import delay_and_sum_pkg::*;
#(
    parameter int SUM_W      = 39,
    parameter int SHIFT      = 0,
    parameter int DOUT_WIDTH = 36
) (
    input  logic [SUM_W-1:0]      sum_i,
    output logic [DOUT_WIDTH-1:0] data_o,
    output logic                  sat_o
);

    wide_t     rounded;
    sat_kind_e kind;

    always_comb begin
        rounded = round_shift(wide_t'($signed(sum_i)), SHIFT);
        kind    = sat_kind(rounded, DOUT_WIDTH);
        sat_o   = (kind != SAT_NONE);
        unique case (kind)
            SAT_HI:  data_o = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
            SAT_LO:  data_o = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
            default: data_o = rounded[DOUT_WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/delay_and_sum_wmac_pipe.sv
// Weighted multiply-accumulate across channels: per-channel weight, pipelined multiply,
// channel sum, then round/shift/saturate into a valid/ready output register.
module delay_and_sum_wmac_pipe
    import delay_and_sum_pkg::*;
#(
    parameter int DIN0_WIDTH = 21,
    parameter int DIN1_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int NUM_STAGE  = 2,
    parameter int SHIFT      = 0,
    parameter int DOUT_WIDTH = 36,
    localparam int PROD_W    = prod_width(DIN0_WIDTH, DIN1_WIDTH),
    localparam int SUM_W     = sum_width(DIN0_WIDTH, DIN1_WIDTH, NUM_CH),
    localparam int AW        = addr_width(NUM_CH)
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*DIN0_WIDTH-1:0] in_data,
    input  logic                         w_we,
    input  logic [AW-1:0]                w_addr,
    input  logic [DIN1_WIDTH-1:0]        w_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DOUT_WIDTH-1:0]        out_data,
    output logic                         out_sat,
    input  logic                         sat_clr,
    output logic                         sat_sticky
);

    logic                     en;
    logic                     accept;
    logic [NUM_STAGE-1:0]     vld_q;
    logic                     sum_vld_q;
    logic                     out_valid_q;
    logic                     out_sat_q;
    logic                     sat_sticky_q;
    logic [NUM_CH*PROD_W-1:0] prod_last;
    logic [SUM_W-1:0]         sum_d;
    logic [SUM_W-1:0]         sum_q;
    logic [DOUT_WIDTH-1:0]    rs_data;
    logic                     rs_sat;
    logic [DOUT_WIDTH-1:0]    out_data_q;

    // One global enable: the whole pipe stalls only when a held output is not taken.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic signed [DIN0_WIDTH-1:0] sample;
        logic signed [DIN1_WIDTH-1:0] weight_q;
        logic signed [PROD_W-1:0]     prod_q [NUM_STAGE];

        assign sample = in_data[gi*DIN0_WIDTH +: DIN0_WIDTH];

        // Out-of-range addresses match no channel, so such writes fall away.
        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                weight_q <= DIN1_WIDTH'(1);
            end else if (w_we && (w_addr == AW'(gi))) begin
                weight_q <= w_data;
            end
        end

        // The first stage multiplies against the weight register as it stands at
        // acceptance, so a same-cycle write only affects later beats.
        always_ff @(posedge ap_clk) begin
            if (en) begin
                prod_q[0] <= PROD_W'(sample) * PROD_W'(weight_q);
                for (int s = 1; s < NUM_STAGE; s++) begin
                    prod_q[s] <= prod_q[s-1];
                end
            end
        end

        assign prod_last[gi*PROD_W +: PROD_W] = prod_q[NUM_STAGE-1];
    end

    always_comb begin
        sum_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum_d = sum_d + SUM_W'($signed(prod_last[c*PROD_W +: PROD_W]));
        end
    end

    always_ff @(posedge ap_clk) begin
        if (en) begin
            sum_q <= sum_d;
        end
    end

    delay_and_sum_round_sat #(
        .SUM_W      (SUM_W),
        .SHIFT      (SHIFT),
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_round_sat (
        .sum_i  (sum_q),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_q       <= '0;
            sum_vld_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (en) begin
            vld_q       <= (vld_q << 1) | NUM_STAGE'(accept);
            sum_vld_q   <= vld_q[NUM_STAGE-1];
            out_valid_q <= sum_vld_q;
            out_data_q  <= rs_data;
            out_sat_q   <= sum_vld_q && rs_sat;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            sat_sticky_q <= 1'b0;
        end else if (en && sum_vld_q && rs_sat) begin
            sat_sticky_q <= 1'b1;
        end else if (sat_clr) begin
            sat_sticky_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sat    = out_sat_q;
    assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_delay_and_sum_wmac_pipe.sv
// Bench for delay_and_sum_wmac_pipe: two instances in lockstep (4 ch / SHIFT 0 and
// 3 ch / SHIFT 4) fed the same stimulus, each checked against its own expected-beat queue.
module tb_delay_and_sum_wmac_pipe;

    localparam int DW = 36;

    typedef struct {
        longint d;
        bit     s;
    } exp_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [83:0] in_data = '0;
    logic        w_we = 1'b0;
    logic [1:0]  w_addr = '0;
    logic [15:0] w_data = '0;
    logic        out_ready = 1'b1;
    logic        sat_clr = 1'b0;

    logic          a_in_ready, a_out_valid, a_out_sat, a_sat_sticky;
    logic [DW-1:0] a_out_data;
    logic          b_in_ready, b_out_valid, b_out_sat, b_sat_sticky;
    logic [DW-1:0] b_out_data;

    int   tests = 0;
    int   fails = 0;
    int   a_beats = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   smp[4];
    int   wa[4];
    int   wb[3];

    bit          hold_a = 0, hold_b = 0;
    logic [36:0] held_a, held_b;

    always #5 ap_clk = ~ap_clk;

    delay_and_sum_wmac_pipe #(
        .DIN0_WIDTH(21), .DIN1_WIDTH(16), .NUM_CH(4), .NUM_STAGE(2), .SHIFT(0), .DOUT_WIDTH(DW)
    ) dut_a (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_sat(a_out_sat), .sat_clr(sat_clr), .sat_sticky(a_sat_sticky)
    );

    delay_and_sum_wmac_pipe #(
        .DIN0_WIDTH(21), .DIN1_WIDTH(16), .NUM_CH(3), .NUM_STAGE(2), .SHIFT(4), .DOUT_WIDTH(DW)
    ) dut_b (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data[62:0]), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_sat(b_out_sat), .sat_clr(sat_clr), .sat_sticky(b_sat_sticky)
    );

    // Reference: exact weighted sum, round half up, clamp to DW signed bits.
    function automatic exp_t calc(input bit is_b);
        exp_t   res;
        longint sum = 0;
        longint r, hi, lo;
        int     n  = is_b ? 3 : 4;
        int     sh = is_b ? 4 : 0;
        for (int c = 0; c < n; c++) begin
            sum += longint'(smp[c]) * longint'(is_b ? wb[c] : wa[c]);
        end
        r  = (sh > 0) ? ((sum + (longint'(1) <<< (sh - 1))) >>> sh) : sum;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -(longint'(1) <<< (DW - 1));
        res.s = (r > hi) || (r < lo);
        res.d = (r > hi) ? hi : ((r < lo) ? lo : r);
        return res;
    endfunction

    task automatic do_reset();
        ap_rst = 1'b1;
        in_valid = 1'b0;
        w_we = 1'b0;
        sat_clr = 1'b0;
        out_ready = 1'b1;
        qa.delete();
        qb.delete();
        for (int c = 0; c < 4; c++) wa[c] = 1;
        for (int c = 0; c < 3; c++) wb[c] = 1;
        repeat (2) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
    endtask

    task automatic set_weight(input int adr, input int val);
        w_we = 1'b1;
        w_addr = 2'(adr);
        w_data = 16'(val);
        @(posedge ap_clk);
        #1 w_we = 1'b0;
        if (adr < 4) wa[adr] = val;
        if (adr < 3) wb[adr] = val;
    endtask

    // Holds the beat until in_ready, queues its expected results, returns just after acceptance.
    task automatic drive_beat(input int s0, input int s1, input int s2, input int s3,
                              input bit we = 1'b0, input int wad = 0, input int wdat = 0);
        int k = 0;
        smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
        for (int c = 0; c < 4; c++) in_data[c*21 +: 21] = 21'(smp[c]);
        in_valid = 1'b1;
        w_we = we;
        w_addr = 2'(wad);
        w_data = 16'(wdat);
        @(negedge ap_clk);
        while (!a_in_ready && k < 50) begin
            @(negedge ap_clk);
            k++;
        end
        if (!a_in_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", a_in_ready, k);
        end
        qa.push_back(calc(1'b0));
        qb.push_back(calc(1'b1));
        @(posedge ap_clk);
        #1 w_we = 1'b0;
        if (we) begin
            if (wad < 4) wa[wad] = wdat;
            if (wad < 3) wb[wad] = wdat;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 100) begin
            @(posedge ap_clk);
            #1 k++;
        end
        tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: pending a=%0d b=%0d, required 0", qa.size(), qb.size());
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, a beat counts when valid && ready.
    initial begin : monitor
        exp_t   e;
        longint got;
        forever begin
            @(negedge ap_clk);
            if (ap_rst) begin
                hold_a = 0;
                hold_b = 0;
            end else begin
                tests++;
                if (a_in_ready !== (!a_out_valid || out_ready) || b_in_ready !== a_in_ready) begin
                    fails++;
                    $display("FAIL in_ready_en: a=%b b=%b required %b", a_in_ready, b_in_ready,
                             !a_out_valid || out_ready);
                end
                if (hold_a) begin
                    tests++;
                    if (a_out_valid !== 1'b1 || {a_out_data, a_out_sat} !== held_a) begin
                        fails++;
                        $display("FAIL stall_hold_a: valid=%b data/sat=%h required held %h",
                                 a_out_valid, {a_out_data, a_out_sat}, held_a);
                    end
                end
                if (hold_b) begin
                    tests++;
                    if (b_out_valid !== 1'b1 || {b_out_data, b_out_sat} !== held_b) begin
                        fails++;
                        $display("FAIL stall_hold_b: valid=%b data/sat=%h required held %h",
                                 b_out_valid, {b_out_data, b_out_sat}, held_b);
                    end
                end
                if (a_out_valid && out_ready) begin
                    tests++;
                    a_beats++;
                    got = $signed(a_out_data);
                    if (qa.size() == 0) begin
                        fails++;
                        $display("FAIL extra_beat_a: data=%0d, required no beat", got);
                    end else begin
                        e = qa.pop_front();
                        if (got !== e.d || a_out_sat !== e.s) begin
                            fails++;
                            $display("FAIL beat_a: data=%0d sat=%b required data=%0d sat=%b",
                                     got, a_out_sat, e.d, e.s);
                        end else begin
                            $display("[TB] beat a data=%0d sat=%b", got, a_out_sat);
                        end
                    end
                end
                if (b_out_valid && out_ready) begin
                    tests++;
                    got = $signed(b_out_data);
                    if (qb.size() == 0) begin
                        fails++;
                        $display("FAIL extra_beat_b: data=%0d, required no beat", got);
                    end else begin
                        e = qb.pop_front();
                        if (got !== e.d || b_out_sat !== e.s) begin
                            fails++;
                            $display("FAIL beat_b: data=%0d sat=%b required data=%0d sat=%b",
                                     got, b_out_sat, e.d, e.s);
                        end else begin
                            $display("[TB] beat b data=%0d sat=%b", got, b_out_sat);
                        end
                    end
                end
                hold_a = a_out_valid && !out_ready;
                held_a = {a_out_data, a_out_sat};
                hold_b = b_out_valid && !out_ready;
                held_b = {b_out_data, b_out_sat};
            end
        end
    end

    task automatic test_reset();
        do_reset();
        tests += 4;
        if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", a_out_valid); end
        if (a_out_data !== '0) begin fails++; $display("FAIL reset_data: got %h required 0", a_out_data); end
        if (a_out_sat !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b required 0", a_out_sat); end
        if (a_sat_sticky !== 1'b0 || b_sat_sticky !== 1'b0) begin
            fails++;
            $display("FAIL reset_sticky: got a=%b b=%b required 0", a_sat_sticky, b_sat_sticky);
        end
    endtask

    task automatic test_unity();
        drive_beat(1000, 1000, 1000, 1000);
        idle();
        for (int k = 1; k <= 3; k++) begin
            @(posedge ap_clk);
            #1 tests++;
            if (a_out_valid !== (k == 3)) begin
                fails++;
                $display("FAIL latency: out_valid=%b at cycle %0d after acceptance, required %b",
                         a_out_valid, k + 1, k == 3);
            end
        end
        wait_drain();
    endtask

    task automatic test_pos_clamp();
        for (int c = 0; c < 4; c++) set_weight(c, -32768);
        drive_beat(-1048576, -1048576, -1048576, -1048576);
        idle();
        wait_drain();
        tests++;
        if (a_sat_sticky !== 1'b1 || b_sat_sticky !== 1'b0) begin
            fails++;
            $display("FAIL sticky_set: got a=%b b=%b required a=1 b=0", a_sat_sticky, b_sat_sticky);
        end
    endtask

    task automatic test_neg_clamp();
        sat_clr = 1'b1;
        @(posedge ap_clk);
        #1 sat_clr = 1'b0;
        tests++;
        if (a_sat_sticky !== 1'b0) begin fails++; $display("FAIL sticky_clr: got %b required 0", a_sat_sticky); end
        for (int c = 0; c < 4; c++) set_weight(c, 32767);
        drive_beat(-1048576, -1048576, -1048576, -1048576);
        idle();
        wait_drain();
        drive_beat(-1048576, -1048576, -1048576, -1048576);
        idle();
        repeat (2) @(posedge ap_clk);
        #1 sat_clr = 1'b1;
        @(posedge ap_clk);
        #1 sat_clr = 1'b0;
        tests++;
        if (a_out_valid !== 1'b1 || a_sat_sticky !== 1'b1) begin
            fails++;
            $display("FAIL sticky_set_wins: valid=%b sticky=%b required 1 1", a_out_valid, a_sat_sticky);
        end
        wait_drain();
        sat_clr = 1'b1;
        @(posedge ap_clk);
        #1 sat_clr = 1'b0;
    endtask

    task automatic test_rounding();
        do_reset();
        for (int c = 1; c < 4; c++) set_weight(c, 0);
        drive_beat(8, 0, 0, 0);
        drive_beat(7, 0, 0, 0);
        drive_beat(24, 0, 0, 0);
        drive_beat(-8, 0, 0, 0);
        drive_beat(-9, 0, 0, 0);
        idle();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int beats0;
        do_reset();
        set_weight(0, 3); set_weight(1, -2); set_weight(2, 5); set_weight(3, -7);
        beats0 = a_beats;
        fork
            begin
                for (int i = 0; i < 6; i++) drive_beat(100 * i + 1, -37 * i, 5 * i, 1 - i);
                idle();
            end
            begin
                repeat (3) @(posedge ap_clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge ap_clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        tests++;
        if (a_beats - beats0 !== 6) begin
            fails++;
            $display("FAIL beat_count: delivered %0d required 6", a_beats - beats0);
        end
    endtask

    task automatic test_weight_timing();
        do_reset();
        drive_beat(10, 10, 10, 10, 1'b1, 2, 3);
        drive_beat(10, 10, 10, 10);
        idle();
        wait_drain();
        set_weight(3, 7);
        drive_beat(10, 10, 10, 10);
        idle();
        wait_drain();
        for (int i = 0; i < 3; i++) drive_beat(i + 1, 2, 3, 4);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(posedge ap_clk);
            #1 tests++;
            if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
                fails++;
                $display("FAIL flush: out_valid a=%b b=%b after reset, required 0", a_out_valid, b_out_valid);
            end
        end
        drive_beat(10, 10, 10, 10);
        idle();
        wait_drain();
    endtask

    initial begin : main
        test_reset();
        test_unity();
        test_pos_clamp();
        test_neg_clamp();
        test_rounding();
        test_back_to_back();
        test_weight_timing();
        repeat (3) @(posedge ap_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
